// File: rtl/tb_check_pkg.sv
// Shared types and helpers for the tb_check_ctrl end-of-test controller.
// Optional logging build macro: TB_CHECK_LOG_EN (see tb_check_ctrl.sv).
package tb_check_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        END_NONE    = 2'd0,
        END_REQ     = 2'd1,
        END_ABORT   = 2'd2,
        END_TIMEOUT = 2'd3
    } end_cause_e;

    // Unsigned add clamped to max_v; callers pass zero-extended operands
    // and truncate the result back to their counter width.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/tb_check_ctrl_popcount.sv
// tb_popcount: combinational population count of a bit vector.
module tb_popcount #(
    parameter int  WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CW-1:0]    count_o
);

    // Sum the set bits of the vector.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/tb_check_ctrl.sv
// tb_check_ctrl: bounded-run controller and multi-channel stream checker.
// Compares NUM_CH expected/actual streams, counts mismatches, captures the
// first failure and produces a done/pass verdict.
// Build option: define TB_CHECK_LOG_EN to print mismatches and the verdict.
module tb_check_ctrl
    import tb_check_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_CYCLES = 32,
    parameter int  CNT_WIDTH  = 16,
    parameter int  FAIL_LIMIT = 0,
    localparam int FF_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         end_req,
    input  logic [NUM_CH-1:0]            chk_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] chk_expect,
    input  logic [NUM_CH*DATA_WIDTH-1:0] chk_actual,
    output logic                         running,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout_flag,
    output logic                         abort_flag,
    output logic [CNT_WIDTH-1:0]         cycle_count,
    output logic [CNT_WIDTH-1:0]         fail_count,
    output logic [NUM_CH-1:0]            fail_ch_mask,
    output logic [FF_W-1:0]              first_fail_ch,
    output logic [CNT_WIDTH-1:0]         first_fail_cycle
);

    localparam int          PC_W      = $clog2(NUM_CH + 1);
    localparam logic [31:0] CNT_MAX   = (CNT_WIDTH >= 32) ? 32'hFFFF_FFFF
                                        : 32'((64'd1 << CNT_WIDTH) - 64'd1);
    localparam logic [31:0] MAX_CYC_U = 32'(MAX_CYCLES);
    localparam logic [31:0] FAIL_LIM_U = 32'(FAIL_LIMIT);

    state_e                state_q, state_d;
    logic                  running_q, running_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic                  abort_q, abort_d;
    logic [CNT_WIDTH-1:0]  cc_q, cc_d;
    logic [CNT_WIDTH-1:0]  fc_q, fc_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [FF_W-1:0]       ffch_q, ffch_d;
    logic [CNT_WIDTH-1:0]  ffcyc_q, ffcyc_d;

    logic [NUM_CH-1:0]     mism_s;
    logic [PC_W-1:0]       pop_s;
    logic [FF_W-1:0]       lowest_s;
    logic [CNT_WIDTH-1:0]  cc_inc_s;
    logic [CNT_WIDTH-1:0]  fc_upd_s;
    logic                  abort_s;
    end_cause_e            end_cause_s;

    // Per-channel compare of strobed expected/actual words.
    always_comb begin
        mism_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mism_s[i] = chk_valid[i] &&
                (chk_expect[i*DATA_WIDTH +: DATA_WIDTH] != chk_actual[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Lowest mismatching channel index this cycle (scan high to low).
    always_comb begin
        lowest_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            lowest_s = mism_s[i] ? FF_W'(i) : lowest_s;
        end
    end

    tb_popcount #(
        .WIDTH (NUM_CH)
    ) u_popcount (
        .vec_i   (mism_s),
        .count_o (pop_s)
    );

    // Updated counters and the prioritised end condition for a RUN cycle.
    always_comb begin
        cc_inc_s = CNT_WIDTH'(sat_add(32'(cc_q), 32'd1, CNT_MAX));
        fc_upd_s = CNT_WIDTH'(sat_add(32'(fc_q), 32'(pop_s), CNT_MAX));
        abort_s  = (FAIL_LIM_U != 32'd0) && (32'(fc_upd_s) >= FAIL_LIM_U);
        if (end_req) begin
            end_cause_s = END_REQ;
        end else if (abort_s) begin
            end_cause_s = END_ABORT;
        end else if (32'(cc_inc_s) >= MAX_CYC_U) begin
            end_cause_s = END_TIMEOUT;
        end else begin
            end_cause_s = END_NONE;
        end
    end

    // Next-state and next-output logic of the run controller.
    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        abort_d   = abort_q;
        cc_d      = cc_q;
        fc_d      = fc_q;
        mask_d    = mask_q;
        ffch_d    = ffch_q;
        ffcyc_d   = ffcyc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    running_d = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    abort_d   = 1'b0;
                    cc_d      = '0;
                    fc_d      = '0;
                    mask_d    = '0;
                    ffch_d    = '0;
                    ffcyc_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                cc_d   = cc_inc_s;
                fc_d   = fc_upd_s;
                mask_d = mask_q | mism_s;
                // An empty sticky mask means no mismatch has been seen yet.
                if ((mism_s != '0) && (mask_q == '0)) begin
                    ffch_d  = lowest_s;
                    ffcyc_d = cc_q;
                end else begin
                    ffch_d  = ffch_q;
                    ffcyc_d = ffcyc_q;
                end
                if (end_cause_s != END_NONE) begin
                    state_d   = S_DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    abort_d   = abort_s;
                    timeout_d = (end_cause_s == END_TIMEOUT);
                    pass_d    = (fc_upd_s == '0) && !abort_s;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d   = S_IDLE;
                running_d = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
            cc_q      <= '0;
            fc_q      <= '0;
            mask_q    <= '0;
            ffch_q    <= '0;
            ffcyc_q   <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
            cc_q      <= cc_d;
            fc_q      <= fc_d;
            mask_q    <= mask_d;
            ffch_q    <= ffch_d;
            ffcyc_q   <= ffcyc_d;
        end
    end

`ifdef TB_CHECK_LOG_EN
    // Report every mismatch and the verdict on entering DONE.
    always @(posedge clk) begin
        if (!rst && (state_q == S_RUN)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (mism_s[i]) begin
                    $display("[tb_check_ctrl] mismatch ch=%0d cycle=%0d exp=%h act=%h",
                             i, cc_q, chk_expect[i*DATA_WIDTH +: DATA_WIDTH],
                             chk_actual[i*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
            if (state_d == S_DONE) begin
                $display("[tb_check_ctrl] %s fail_count=%0d cause=%s",
                         pass_d ? "PASSED" : "FAILED", fc_upd_s, end_cause_s.name());
            end
        end
    end
`endif

    assign running          = running_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign timeout_flag     = timeout_q;
    assign abort_flag       = abort_q;
    assign cycle_count      = cc_q;
    assign fail_count       = fc_q;
    assign fail_ch_mask     = mask_q;
    assign first_fail_ch    = ffch_q;
    assign first_fail_cycle = ffcyc_q;

endmodule

// File: tb/tb_tb_check_ctrl.sv
// Bench for tb_check_ctrl: four configurations share one stimulus stream;
// a behavioural model predicts every instance each cycle, and directed
// literal checks pin the scenarios of interest.
module tb_tb_check_ctrl;

    typedef struct packed {
        logic        r, d, p, t, a;
        logic [15:0] cc, fc;
        logic [3:0]  mask;
        logic [1:0]  ffch;
        logic [15:0] ffcyc;
    } snap_t;

    // Instance configs: 0 default, 1 FAIL_LIMIT=2, 2 CNT_WIDTH=4/MAX=8, 3 MAX=1
    localparam int P_MAX [4] = '{32, 32, 8, 1};
    localparam int P_CW  [4] = '{16, 16, 4, 16};
    localparam int P_FL  [4] = '{0, 2, 0, 0};

    logic         clk = 1'b0;
    logic         rst, start, end_req;
    logic [3:0]   chk_valid;
    logic [127:0] chk_expect, chk_actual;

    logic [3:0]        r_s, d_s, p_s, t_s, a_s;
    logic [3:0][15:0]  cc_s, fc_s, ffcyc_s;
    logic [3:0][3:0]   mask_s;
    logic [3:0][1:0]   ffch_s;
    logic [3:0]        cc_c, fc_c, ffcyc_c;

    snap_t m [4];
    snap_t cmp_a;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    stim_n  = 0;
    logic  chk_en  = 1'b0;

    always #5 clk = ~clk;

    tb_check_ctrl u_a (
        .clk(clk), .rst(rst), .start(start), .end_req(end_req), .chk_valid(chk_valid),
        .chk_expect(chk_expect), .chk_actual(chk_actual), .running(r_s[0]), .done(d_s[0]),
        .pass(p_s[0]), .timeout_flag(t_s[0]), .abort_flag(a_s[0]), .cycle_count(cc_s[0]),
        .fail_count(fc_s[0]), .fail_ch_mask(mask_s[0]), .first_fail_ch(ffch_s[0]),
        .first_fail_cycle(ffcyc_s[0]));

    tb_check_ctrl #(.FAIL_LIMIT(2)) u_b (
        .clk(clk), .rst(rst), .start(start), .end_req(end_req), .chk_valid(chk_valid),
        .chk_expect(chk_expect), .chk_actual(chk_actual), .running(r_s[1]), .done(d_s[1]),
        .pass(p_s[1]), .timeout_flag(t_s[1]), .abort_flag(a_s[1]), .cycle_count(cc_s[1]),
        .fail_count(fc_s[1]), .fail_ch_mask(mask_s[1]), .first_fail_ch(ffch_s[1]),
        .first_fail_cycle(ffcyc_s[1]));

    tb_check_ctrl #(.CNT_WIDTH(4), .MAX_CYCLES(8)) u_c (
        .clk(clk), .rst(rst), .start(start), .end_req(end_req), .chk_valid(chk_valid),
        .chk_expect(chk_expect), .chk_actual(chk_actual), .running(r_s[2]), .done(d_s[2]),
        .pass(p_s[2]), .timeout_flag(t_s[2]), .abort_flag(a_s[2]), .cycle_count(cc_c),
        .fail_count(fc_c), .fail_ch_mask(mask_s[2]), .first_fail_ch(ffch_s[2]),
        .first_fail_cycle(ffcyc_c));

    tb_check_ctrl #(.MAX_CYCLES(1)) u_d (
        .clk(clk), .rst(rst), .start(start), .end_req(end_req), .chk_valid(chk_valid),
        .chk_expect(chk_expect), .chk_actual(chk_actual), .running(r_s[3]), .done(d_s[3]),
        .pass(p_s[3]), .timeout_flag(t_s[3]), .abort_flag(a_s[3]), .cycle_count(cc_s[3]),
        .fail_count(fc_s[3]), .fail_ch_mask(mask_s[3]), .first_fail_ch(ffch_s[3]),
        .first_fail_cycle(ffcyc_s[3]));

    assign cc_s[2]    = {12'd0, cc_c};
    assign fc_s[2]    = {12'd0, fc_c};
    assign ffcyc_s[2] = {12'd0, ffcyc_c};

    function automatic snap_t dut_snap(input int k);
        snap_t s;
        s.r = r_s[k]; s.d = d_s[k]; s.p = p_s[k]; s.t = t_s[k]; s.a = a_s[k];
        s.cc = cc_s[k]; s.fc = fc_s[k]; s.mask = mask_s[k];
        s.ffch = ffch_s[k]; s.ffcyc = ffcyc_s[k];
        return s;
    endfunction

    // Model: what each instance must show after this clock, from the rules.
    function automatic snap_t model_step(input snap_t s, input int k);
        snap_t      n;
        int         cap, cnt, first, cc_new, fc_new;
        logic [3:0] mm;
        logic       ab, to;
        n = s;
        if (rst) return '0;
        if (!s.r) begin
            if (start) begin
                n   = '0;
                n.r = 1'b1;
            end
            return n;
        end
        mm = 4'd0; cnt = 0; first = -1;
        for (int ch = 0; ch < 4; ch++) begin
            if (chk_valid[ch] && (chk_expect[ch*32 +: 32] != chk_actual[ch*32 +: 32])) begin
                mm[ch] = 1'b1;
                cnt++;
                if (first < 0) first = ch;
            end
        end
        cap = (1 << P_CW[k]) - 1;
        if (cnt > 0 && s.mask == 4'd0) begin
            n.ffch  = 2'(first);
            n.ffcyc = s.cc;
        end
        cc_new = int'(s.cc) + 1;      if (cc_new > cap) cc_new = cap;
        fc_new = int'(s.fc) + cnt;    if (fc_new > cap) fc_new = cap;
        n.cc   = 16'(cc_new);
        n.fc   = 16'(fc_new);
        n.mask = s.mask | mm;
        ab = (P_FL[k] != 0) && (fc_new >= P_FL[k]);
        to = !end_req && !ab && (cc_new >= P_MAX[k]);
        if (end_req || ab || to) begin
            n.r = 1'b0; n.d = 1'b1; n.a = ab; n.t = to;
            n.p = (fc_new == 0) && !ab;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) m[k] <= model_step(m[k], k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                cmp_a = dut_snap(k);
                n_tests++;
                if (cmp_a !== m[k]) begin
                    n_fail++;
                    $display("FAIL model_cmp inst=%0d t=%0t: dut=%h model=%h", k, $time, cmp_a, m[k]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus: valid mask, channels to corrupt, end request.
    task automatic step(input logic [3:0] vm, input logic [3:0] mm, input logic er);
        chk_valid = vm;
        end_req   = er;
        for (int ch = 0; ch < 4; ch++) begin
            chk_expect[ch*32 +: 32] = 32'hA5A5_0000 + 32'(stim_n * 16 + ch);
            chk_actual[ch*32 +: 32] = chk_expect[ch*32 +: 32] ^ (mm[ch] ? (32'h1 << ch) : 32'h0);
        end
        stim_n++;
        @(negedge clk);
        end_req = 1'b0;
    endtask

    task automatic clean(input int n);
        repeat (n) step(4'hF, 4'h0, 1'b0);
    endtask

    task automatic begin_run(input logic [3:0] mm);
        start = 1'b1;
        step(4'hF, mm, 1'b0);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; end_req = 1'b0;
        chk_valid = 4'h0; chk_expect = '0; chk_actual = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_running", int'(r_s[0]), 0);
        check("reset_cc", int'(cc_s[0]), 0);
        rst = 1'b0;

        // Clean run; mismatch during the start cycle is outside RUN.
        begin_run(4'b0100);
        clean(32);
        check("clean_done", int'(d_s[0]), 1);
        check("clean_timeout", int'(t_s[0]), 1);
        check("clean_pass", int'(p_s[0]), 1);
        check("clean_fc", int'(fc_s[0]), 0);
        check("clean_cc", int'(cc_s[0]), 32);
        check("max1_cc", int'(cc_s[3]), 1);
        check("max1_timeout", int'(t_s[3]), 1);

        // Multi-fail with an invalid mismatching channel at cycle 6.
        begin_run(4'h0);
        clean(5);
        step(4'hF, 4'b1010, 1'b0);
        step(4'b1101, 4'b0010, 1'b0);
        clean(2);
        step(4'hF, 4'b0010, 1'b0);
        clean(22);
        check("multi_fc", int'(fc_s[0]), 3);
        check("multi_mask", int'(mask_s[0]), 10);
        check("multi_ffch", int'(ffch_s[0]), 1);
        check("multi_ffcyc", int'(ffcyc_s[0]), 5);
        check("multi_pass", int'(p_s[0]), 0);
        check("multi_done", int'(d_s[0]), 1);

        // Early end at cycle 10.
        begin_run(4'h0);
        clean(10);
        step(4'hF, 4'h0, 1'b1);
        check("early_cc", int'(cc_s[0]), 11);
        check("early_done", int'(d_s[0]), 1);
        check("early_timeout", int'(t_s[0]), 0);
        check("early_pass", int'(p_s[0]), 1);

        // Abort with FAIL_LIMIT=2.
        begin_run(4'h0);
        clean(3);
        step(4'hF, 4'b0001, 1'b0);
        step(4'hF, 4'b0001, 1'b0);
        check("abort_flag", int'(a_s[1]), 1);
        check("abort_cc", int'(cc_s[1]), 5);
        check("abort_pass", int'(p_s[1]), 0);
        check("abort_timeout", int'(t_s[1]), 0);
        step(4'hF, 4'h0, 1'b1);

        // end_req coinciding with the fail limit still flags abort.
        begin_run(4'h0);
        step(4'hF, 4'b0011, 1'b1);
        check("coin_abort", int'(a_s[1]), 1);
        check("coin_fc", int'(fc_s[1]), 2);
        check("coin_noabort_a", int'(a_s[0]), 0);
        check("coin_pass_a", int'(p_s[0]), 0);

        // Fail counter saturation at CNT_WIDTH=4.
        begin_run(4'h0);
        repeat (8) step(4'hF, 4'hF, 1'b0);
        check("sat_fc", int'(fc_s[2]), 15);
        check("sat_timeout", int'(t_s[2]), 1);
        check("sat_cc", int'(cc_s[2]), 8);
        step(4'hF, 4'h0, 1'b1);
        check("sat_hold", int'(fc_s[2]), 15);

        // Reset mid-run, then a fresh run that ignores a stray start.
        begin_run(4'h0);
        clean(2);
        step(4'hF, 4'b0100, 1'b0);
        clean(4);
        rst = 1'b1;
        step(4'hF, 4'h0, 1'b0);
        rst = 1'b0;
        check("rst_fc", int'(fc_s[0]), 0);
        check("rst_running", int'(r_s[0]), 0);
        check("rst_mask", int'(mask_s[0]), 0);
        begin_run(4'h0);
        clean(2);
        start = 1'b1;
        step(4'hF, 4'h0, 1'b0);
        start = 1'b0;
        clean(1);
        check("rerun_cc", int'(cc_s[0]), 4);
        check("rerun_running", int'(r_s[0]), 1);
        step(4'hF, 4'h0, 1'b1);
        check("rerun_pass", int'(p_s[0]), 1);
        check("rerun_cc_end", int'(cc_s[0]), 5);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
